// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run-time controller for a clock divider.
// Holds the active divide ratio and takes new ratios over a valid/ready
// handshake. A new ratio takes effect only at a period boundary, so no output
// period is ever cut short. The output starts and stops cleanly on enable.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   enable       1 = run; 0 = stop at the end of the current period
//   cfg_valid    a new ratio is offered on cfg_div
//   cfg_div      requested ratio N (output period = N clk cycles)
//   cfg_ready    combinational; a ratio can be accepted this cycle
//   cfg_err      one-cycle pulse: accepted ratio was < 2 and was discarded
//   clk_div_out  divided output, high floor(N/2) cycles, low the rest
//   tick         one-cycle pulse in the first cycle of every period
//   busy         controller is not idle
//
// state | meaning
// IDLE  | divider stopped, ratio writes go straight to active_q
// RUN   | counting a period, no ratio waiting
// PEND  | counting a period, pending_q is applied at the next boundary

module freq_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100  // must lie in 2 .. 2**CNT_W-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             legal;
  logic             at_b;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;

  assign cfg_ready   = (state_q != PEND);
  assign xfer        = cfg_valid & cfg_ready;
  assign legal       = (cfg_div >= CNT_W'(2));
  assign at_b        = (state_q != IDLE) && (cnt_q == active_q - CNT_W'(1));
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign half        = active_q >> 1;

  assign busy        = (state_q != IDLE);
  assign clk_div_out = out_q;
  assign tick        = tick_q;
  assign cfg_err     = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    err_d     = xfer & ~legal;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        out_d = 1'b0;
        // A ratio offered together with enable sizes the very first period.
        if (xfer && legal) active_d = cfg_div;
        if (enable) begin
          state_d = RUN;
          out_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, PEND: begin
        if (at_b) begin
          // PEND never sees a transfer (cfg_ready is low), so the two
          // sources of a new ratio cannot collide.
          if (state_q == PEND)     active_d = pending_q;
          else if (xfer && legal)  active_d = cfg_div;
          cnt_d = '0;
          if (enable) begin
            state_d = RUN;
            out_d   = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = IDLE;
            out_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          out_d = (cnt_inc < half);
          if (state_q == RUN && xfer && legal) begin
            pending_d = cfg_div;
            state_d   = PEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= CNT_W'(DEFAULT_DIV);
      pending_q <= '0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Run-time controller for the clock divider.
- Holds the active divide ratio and accepts new ratios over a valid/ready config handshake.
- Applies new ratios only at period boundaries, so there is never a truncated or runt output period.
- Starts and stops the divided output gracefully on `enable`. Generates the divided output (a clock-enable style, 1-clk-domain signal) plus a per-period tick for downstream schedulers.

Parameters:
- CNT_W, 16, width of the ratio and the period counter.
- DEFAULT_DIV, 100, ratio loaded at reset; must be in 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run divider, 0 = stop at the end of the current period.
- cfg_valid  input  1  a new ratio is offered on cfg_div.
- cfg_div  input  CNT_W  requested divide ratio N (output period = N clk cycles).
- cfg_ready  output  1  combinational; 1 when a ratio can be accepted.
- cfg_err  output  1  one-cycle pulse: the accepted ratio was illegal (N<2) and was discarded.
- clk_div_out  output  1  divided output: high floor(N/2) cycles, low N-floor(N/2) cycles.
- tick  output  1  one-cycle pulse in the first cycle of every output period.
- busy  output  1  1 when state != IDLE.

Behaviour:
- Reset (async): state=IDLE, cnt=0, active_div=DEFAULT_DIV, pending_div=0, clk_div_out=0, tick=0, cfg_err=0. cfg_ready=1 immediately after reset.
- States: IDLE, RUN, PEND (RUN with a ratio waiting). busy=(state!=IDLE). cfg_ready=(state!=PEND).
- Handshake: a transfer occurs when cfg_valid&cfg_ready are both high at a clk edge. cfg_valid held while cfg_ready=0 simply waits.
- Illegal ratio (cfg_div<2) on a transfer: transfer completes, cfg_err=1 the next cycle, no state or ratio change.
- Boundary cycle ("B"): state is RUN or PEND and cnt==active_div-1.
- IDLE:
  - A legal transfer writes active_div directly (next cycle).
  - On enable=1: next cycle state=RUN, cnt=0, clk_div_out=1, tick=1. The first period uses the ratio transferred in the same cycle if one occurred, else active_div.
- RUN, non-B cycle: cnt+1; tick=0; clk_div_out=((cnt+1) < active_div>>1). A legal transfer goes to pending_div, state becomes PEND.
- RUN, B cycle: a legal transfer in this same cycle becomes active_div directly for the next period (no PEND).
- PEND: counting as in RUN. At B: active_div<=pending_div, state=RUN (or IDLE, see below).
- At any B with enable=1: cnt=0, tick=1, clk_div_out=1; the next period uses the updated active_div.
- At any B with enable=0: state=IDLE, cnt=0, tick=0, clk_div_out=0. A pending ratio is still applied to active_div.
- enable is sampled only at B while running. A 0 then 1 within one period causes no gap.
- Reset asserted mid-period: all outputs go to reset values asynchronously. Any pending ratio is lost and active_div returns to DEFAULT_DIV.
- Latency: enable to first tick is 1 cycle. The config change is visible from the first period starting after the transfer.
- Counter arithmetic: unsigned CNT_W bits. cnt never exceeds active_div-1, so there is no wrap beyond that.

Test Plan:
- Reset release, enable=1, default 100 -> tick every 100 cycles; clk_div_out high 50 / low 50; first tick 1 cycle after enable.
- In RUN, at cnt=10 transfer cfg_div=7 -> cfg_ready=0 until boundary; current 100-cycle period completes; then period 7 (high 3, low 4), cfg_ready=1 again.
- Transfer cfg_div=1 while running -> cfg_err pulses 1 cycle; period stays 100; state unchanged; cfg_ready stays 1.
- Drop enable at cnt=20 with ratio 100 -> period finishes at cnt=99; next cycle busy=0, clk_div_out=0, no tick. Re-pulse enable low-then-high inside a period -> no gap.
- IDLE with cfg_valid=1, cfg_div=4 and enable=1 in the same cycle -> first period is 4 cycles (high 2, low 2). cfg_div=3 -> high 1, low 2.
- Assert reset at cnt=40 with pending 7 -> outputs 0 immediately; after release and enable, period is 100 (pending discarded).
